// File: rtl/mem_access_ctrl.sv
// Load/store access controller sitting in front of the 4 KB data memory.
// Takes one CPU request at a time, rejects misaligned or out-of-range
// accesses, holds legal accesses at the memory for 1+WAIT_CYCLES cycles,
// captures load data and reports completion with a one-cycle done pulse.
module mem_access_ctrl #(
  parameter int unsigned WAIT_CYCLES = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic        we,
  input  logic        byte_en,
  input  logic        sign_ext,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic        done,
  output logic        fault,
  output logic [31:0] rdata,
  output logic        mRD,
  output logic        mWR,
  output logic        Byte,
  output logic        SigCtr,
  output logic [11:0] DAddr,
  output logic [31:0] DataIn,
  input  logic [31:0] DataOut
);

  localparam logic [3:0] WaitInit = 4'(WAIT_CYCLES);

  typedef enum logic [1:0] {StIdle, StAccess, StResp} state_e;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        we_q, we_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        fault_q, fault_d;
  logic        mrd_q, mrd_d;
  logic        mwr_q, mwr_d;
  logic        byte_q, byte_d;
  logic        sig_q, sig_d;
  logic [11:0] daddr_q, daddr_d;
  logic [31:0] datain_q, datain_d;
  logic [31:0] rdata_q, rdata_d;

  logic misaligned, out_of_range, req_fault;

  // Legality of the request currently presented on the inputs.
  always_comb begin
    misaligned   = ~byte_en & (addr[1:0] != 2'b00);
    out_of_range = (addr[31:12] != 20'h0);
    req_fault    = misaligned | out_of_range;
  end

  // Next-state and next-output logic; every output is registered, so the
  // values computed here are what the memory and CPU see next cycle.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    we_d     = we_q;
    busy_d   = 1'b0;
    done_d   = 1'b0;
    fault_d  = 1'b0;
    mrd_d    = 1'b0;
    mwr_d    = 1'b0;
    byte_d   = byte_q;
    sig_d    = sig_q;
    daddr_d  = daddr_q;
    datain_d = datain_q;
    rdata_d  = rdata_q;

    unique case (state_q)
      StIdle: begin
        if (req) begin
          we_d = we;
          if (req_fault) begin
            // Rejected accesses never touch the memory.
            state_d = StResp;
            done_d  = 1'b1;
            fault_d = 1'b1;
          end else begin
            state_d  = StAccess;
            busy_d   = 1'b1;
            mrd_d    = ~we;
            mwr_d    = we;
            byte_d   = byte_en;
            sig_d    = sign_ext;
            daddr_d  = addr[11:0];
            datain_d = wdata;
            cnt_d    = WaitInit;
          end
        end
      end

      StAccess: begin
        if (cnt_q == 4'd0) begin
          state_d = StResp;
          done_d  = 1'b1;
          if (!we_q) begin
            rdata_d = DataOut;
          end
        end else begin
          // Store strobe was only in the first cycle; reads stay asserted.
          cnt_d  = cnt_q - 4'd1;
          busy_d = 1'b1;
          mrd_d  = ~we_q;
        end
      end

      StResp: begin
        state_d = StIdle;
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State and output registers with synchronous reset taking priority.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      cnt_q    <= 4'd0;
      we_q     <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      fault_q  <= 1'b0;
      mrd_q    <= 1'b0;
      mwr_q    <= 1'b0;
      byte_q   <= 1'b0;
      sig_q    <= 1'b0;
      daddr_q  <= 12'h0;
      datain_q <= 32'h0;
      rdata_q  <= 32'h0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      we_q     <= we_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      fault_q  <= fault_d;
      mrd_q    <= mrd_d;
      mwr_q    <= mwr_d;
      byte_q   <= byte_d;
      sig_q    <= sig_d;
      daddr_q  <= daddr_d;
      datain_q <= datain_d;
      rdata_q  <= rdata_d;
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign fault  = fault_q;
  assign rdata  = rdata_q;
  assign mRD    = mrd_q;
  assign mWR    = mwr_q;
  assign Byte   = byte_q;
  assign SigCtr = sig_q;
  assign DAddr  = daddr_q;
  assign DataIn = datain_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Bench for mem_access_ctrl: instance 0 with no wait states, instance 1 with
// two. Each instance has its own data memory. A timeline model predicts
// every output each cycle; directed accesses also carry literal expectations.
module tb_mem_access_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]        rst_v, req_v;
  logic              we, byte_en, sign_ext, mem_init;
  logic [31:0]       addr, wdata;
  logic [1:0]        busy_v, done_v, fault_v, mrd_v, mwr_v, byte_v, sig_v;
  logic [1:0][11:0]  daddr_v;
  logic [1:0][31:0]  datain_v, rdata_v;

  int checks = 0;
  int errors = 0;

  for (genvar g = 0; g < 2; g++) begin : g_inst
    logic        busy, done, fault, mrd, mwr, bsel, sctl;
    logic [11:0] daddr;
    logic [31:0] datain, rdata, dout, rw;
    logic [7:0]  rb;
    logic [31:0] mem [1024];

    mem_access_ctrl #(.WAIT_CYCLES(g == 0 ? 0 : 2)) u_dut (
      .clk(clk), .rst(rst_v[g]), .req(req_v[g]), .we(we), .byte_en(byte_en),
      .sign_ext(sign_ext), .addr(addr), .wdata(wdata), .busy(busy), .done(done),
      .fault(fault), .rdata(rdata), .mRD(mrd), .mWR(mwr), .Byte(bsel),
      .SigCtr(sctl), .DAddr(daddr), .DataIn(datain), .DataOut(dout)
    );

    // Data memory: little-endian byte lanes, write on the clock edge.
    always @(posedge clk) begin
      if (mem_init) begin
        for (int k = 0; k < 1024; k++) mem[k] <= (k == 0) ? 32'h11223344 : 32'h0;
      end else if (mwr) begin
        if (bsel) mem[daddr[11:2]][{daddr[1:0], 3'b000} +: 8] <= datain[7:0];
        else      mem[daddr[11:2]] <= datain;
      end
    end

    always_comb begin
      rw = mem[daddr[11:2]];
      rb = rw[{daddr[1:0], 3'b000} +: 8];
      if (bsel) dout = sctl ? {{24{rb[7]}}, rb} : {24'h0, rb};
      else      dout = rw;
    end

    assign busy_v[g]   = busy;
    assign done_v[g]   = done;
    assign fault_v[g]  = fault;
    assign mrd_v[g]    = mrd;
    assign mwr_v[g]    = mwr;
    assign byte_v[g]   = bsel;
    assign sig_v[g]    = sctl;
    assign daddr_v[g]  = daddr;
    assign datain_v[g] = datain;
    assign rdata_v[g]  = rdata;
  end

  task automatic check(input string nm, input int i, input logic [31:0] got,
                       input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s inst%0d t=%0t got %h want %h", nm, i, $time, got, want);
    end
  endtask

  // ---------------- timeline model ----------------
  int          wc [2] = '{0, 2};
  int          cyc = 0;
  bit          mon_on = 1'b0;
  bit          act [2], legal [2], mwe [2];
  int          t_acc [2], t_resp [2];
  logic [31:0] ld_val [2], exp_rdata [2], exp_datain [2];
  logic [11:0] exp_daddr [2];
  logic        exp_byte [2], exp_sig [2];
  logic [31:0] ref_mem [2][1024];

  function automatic logic [31:0] ref_load(input int i, input logic [31:0] a,
                                           input logic b, input logic s);
    logic [31:0] w;
    logic [7:0]  bb;
    w  = ref_mem[i][a[11:2]];
    bb = 8'(w >> (int'(a[1:0]) * 8));
    if (!b) return w;
    return s ? {{24{bb[7]}}, bb} : {24'h0, bb};
  endfunction

  task automatic ref_store(input int i, input logic [31:0] a, input logic b,
                           input logic [31:0] d);
    int sh;
    sh = int'(a[1:0]) * 8;
    if (b) ref_mem[i][a[11:2]] = (ref_mem[i][a[11:2]] & ~(32'hFF << sh)) |
                                 ({24'h0, d[7:0]} << sh);
    else   ref_mem[i][a[11:2]] = d;
  endtask

  // Compare this cycle's outputs, then advance the model across the next edge
  // using the inputs that edge will sample.
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      bit in_acc, e_done;
      int n;
      in_acc = act[i] && legal[i] && cyc >= t_acc[i] && cyc <= t_acc[i] + wc[i];
      e_done = act[i] && cyc == t_resp[i];
      if (mon_on) begin
        check("busy",   i, 32'(busy_v[i]),  32'(in_acc));
        check("mRD",    i, 32'(mrd_v[i]),   32'(in_acc && !mwe[i]));
        check("mWR",    i, 32'(mwr_v[i]),
              32'(act[i] && legal[i] && mwe[i] && cyc == t_acc[i]));
        check("done",   i, 32'(done_v[i]),  32'(e_done));
        check("fault",  i, 32'(fault_v[i]), 32'(e_done && !legal[i]));
        check("rdata",  i, rdata_v[i], exp_rdata[i]);
        check("DAddr",  i, 32'(daddr_v[i]), 32'(exp_daddr[i]));
        check("DataIn", i, datain_v[i], exp_datain[i]);
        check("Byte",   i, 32'(byte_v[i]),  32'(exp_byte[i]));
        check("SigCtr", i, 32'(sig_v[i]),   32'(exp_sig[i]));
      end
      n = cyc + 1;
      if (rst_v[i]) begin
        act[i] = 1'b0;
        exp_rdata[i] = '0; exp_datain[i] = '0; exp_daddr[i] = '0;
        exp_byte[i] = 1'b0; exp_sig[i] = 1'b0;
      end else begin
        if (act[i] && legal[i] && !mwe[i] && n == t_resp[i]) exp_rdata[i] = ld_val[i];
        if (req_v[i] && (!act[i] || n >= t_resp[i] + 2)) begin
          act[i]   = 1'b1;
          t_acc[i] = n;
          mwe[i]   = we;
          legal[i] = !((!byte_en && addr[1:0] != 2'b00) || addr[31:12] != 20'h0);
          t_resp[i] = legal[i] ? n + 1 + wc[i] : n;
          if (legal[i]) begin
            exp_daddr[i] = addr[11:0]; exp_datain[i] = wdata;
            exp_byte[i] = byte_en; exp_sig[i] = sign_ext;
            if (we) ref_store(i, addr, byte_en, wdata);
            else    ld_val[i] = ref_load(i, addr, byte_en, sign_ext);
          end
        end
      end
    end
    cyc++;
  end

  // ---------------- directed stimulus ----------------
  task automatic access(input int i, input logic w, input logic b, input logic s,
                        input logic [31:0] a, input logic [31:0] d, input bit tog,
                        output int lat, output logic f, output logic [31:0] rd,
                        output int nrd, output int nwr);
    @(posedge clk); #1;
    we = w; byte_en = b; sign_ext = s; addr = a; wdata = d; req_v[i] = 1'b1;
    lat = -1; nrd = 0; nwr = 0; f = 1'b0; rd = '0;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk); #1;
      if (tog) req_v[i] = (k == 1);
      #3;
      nrd += int'(mrd_v[i]);
      nwr += int'(mwr_v[i]);
      if (done_v[i]) begin
        lat = k + 1; f = fault_v[i]; rd = rdata_v[i];
        break;
      end
    end
    if (lat < 0) begin
      checks++; errors++;
      $display("FAIL timeout inst%0d addr %h: no done within 20 cycles", i, a);
    end
    @(posedge clk); #1;
    req_v[i] = 1'b0;
  endtask

  task automatic run(input string nm, input int i, input logic w, input logic b,
                     input logic s, input logic [31:0] a, input logic [31:0] d,
                     input bit tog, input int e_lat, input logic e_f,
                     input logic [31:0] e_rd, input int e_nrd, input int e_nwr);
    int lat, nrd, nwr;
    logic f;
    logic [31:0] rd;
    access(i, w, b, s, a, d, tog, lat, f, rd, nrd, nwr);
    check({nm, "_lat"},   i, 32'(lat), 32'(e_lat));
    check({nm, "_fault"}, i, 32'(f),   32'(e_f));
    check({nm, "_rdata"}, i, rd, e_rd);
    check({nm, "_nrd"},   i, 32'(nrd), 32'(e_nrd));
    check({nm, "_nwr"},   i, 32'(nwr), 32'(e_nwr));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int nb, nd;
    for (int i = 0; i < 2; i++)
      for (int k = 0; k < 1024; k++) ref_mem[i][k] = (k == 0) ? 32'h11223344 : 32'h0;
    rst_v = 2'b11; req_v = 2'b00; mem_init = 1'b1;
    we = 1'b0; byte_en = 1'b0; sign_ext = 1'b0; addr = '0; wdata = '0;
    @(posedge clk); #1 mem_init = 1'b0;
    @(posedge clk); #1 rst_v = 2'b00; mon_on = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      check("rst_busy",  i, 32'(busy_v[i]), 32'h0);
      check("rst_rdata", i, rdata_v[i], 32'h0);
      check("rst_daddr", i, 32'(daddr_v[i]), 32'h0);
    end

    // Zero wait states: name, inst, we, byte, sign, addr, wdata, tog,
    // latency, fault, rdata, mRD cycles, mWR cycles.
    run("st_w",      0, 1, 0, 0, 32'h104,      32'hDEADBEEF, 0, 2, 0, 32'h0,        0, 1);
    run("ld_w",      0, 0, 0, 0, 32'h104,      32'h0,        0, 2, 0, 32'hDEADBEEF, 1, 0);
    run("st_w2",     0, 1, 0, 0, 32'h104,      32'h80FF1234, 0, 2, 0, 32'hDEADBEEF, 0, 1);
    run("ld_sb107",  0, 0, 1, 1, 32'h107,      32'h0,        0, 2, 0, 32'hFFFFFF80, 1, 0);
    run("ld_ub107",  0, 0, 1, 0, 32'h107,      32'h0,        0, 2, 0, 32'h00000080, 1, 0);
    run("ld_ub104",  0, 0, 1, 0, 32'h104,      32'h0,        0, 2, 0, 32'h00000034, 1, 0);
    run("ld_mis",    0, 0, 0, 0, 32'h102,      32'h0,        0, 1, 1, 32'h00000034, 0, 0);
    run("st_oor",    0, 1, 1, 0, 32'h1000,     32'hAA,       0, 1, 1, 32'h00000034, 0, 0);
    run("ld_w0",     0, 0, 0, 0, 32'h000,      32'h0,        0, 2, 0, 32'h11223344, 1, 0);
    run("st_b105",   0, 1, 1, 0, 32'h105,      32'h12345655, 0, 2, 0, 32'h11223344, 0, 1);
    run("ld_w104",   0, 0, 0, 0, 32'h104,      32'h0,        0, 2, 0, 32'h80FF5534, 1, 0);
    run("ld_hi",     0, 0, 0, 0, 32'h80000104, 32'h0,        0, 1, 1, 32'h80FF5534, 0, 0);
    run("ld_sb106",  0, 0, 1, 1, 32'h106,      32'h0,        0, 2, 0, 32'hFFFFFFFF, 1, 0);

    // Two wait states.
    run("w2_ld0",    1, 0, 0, 0, 32'h000,      32'h0,        0, 4, 0, 32'h11223344, 3, 0);
    run("w2_st",     1, 1, 0, 0, 32'h104,      32'hCAFEF00D, 0, 4, 0, 32'h11223344, 0, 1);
    run("w2_tog",    1, 0, 0, 0, 32'h104,      32'h0,        1, 4, 0, 32'hCAFEF00D, 3, 0);
    nb = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      nb += int'(busy_v[1]);
    end
    check("w2_tog_noextra", 1, 32'(nb), 32'h0);

    // Reset during the second access cycle of a load.
    @(posedge clk); #1;
    we = 1'b0; byte_en = 1'b0; sign_ext = 1'b0; addr = 32'h0; req_v[1] = 1'b1;
    @(posedge clk); #1 req_v[1] = 1'b0;
    @(posedge clk); #1 rst_v[1] = 1'b1;
    #3 check("rst_pre_mrd", 1, 32'(mrd_v[1]), 32'h1);
    @(posedge clk); #1 rst_v[1] = 1'b0;
    #3;
    check("rst_mid_busy",  1, 32'(busy_v[1]), 32'h0);
    check("rst_mid_mrd",   1, 32'(mrd_v[1]),  32'h0);
    check("rst_mid_rdata", 1, rdata_v[1],     32'h0);
    nd = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      nd += int'(done_v[1]);
    end
    check("rst_mid_nodone", 1, 32'(nd), 32'h0);

    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
